led_digits_scheduler: RTL

- Time-shares the 8-digit seven-segment display between NUM_CLIENTS requesters.
- Round-robin arbitration; each grant holds the display for a fixed dwell, then a blanking gap follows.
- Drives the display's 56-bit all-digits segment input (digit 1 in [55:49] … digit 8 in [6:0]); display scan timing is unchanged.
- Sits between status sources (firmware, error monitor, counters) and the display driver.

---
 rtl/led_digits_pkg.sv | 18 +
 rtl/led_digits_scheduler_rr_arbiter.sv | 32 +++
 rtl/led_digits_scheduler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/led_digits_pkg.sv
// Shared definitions for the seven-segment display scheduler: FSM state
// encoding and the 8-digit x 7-segment packing constants.
package led_digits_pkg;

  localparam int SEG_BITS_C   = 56;
  localparam int DIGIT_BITS_C = 7;
  localparam int NUM_DIGITS_C = 8;

  localparam logic [SEG_BITS_C-1:0] BLANK_PATTERN_C = 56'h0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHOW,
    ST_BLANK
  } sched_state_e;

endpackage

// File: rtl/led_digits_scheduler_rr_arbiter.sv
// Combinational round-robin picker: returns the first requester found when
// scanning upward from the pointer (wrapping), as one-hot and as an index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] index
);

  logic          found;
  logic [IW-1:0] cand;

  // First set request at or after the pointer wins.
  always_comb begin
    onehot = '0;
    index  = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(pointer) + i) % N);
      if (!found && req[cand]) begin
        found         = 1'b1;
        onehot[cand]  = 1'b1;
        index         = cand;
      end
    end
  end

endmodule

// File: rtl/led_digits_scheduler.sv
// Time-shares the 8-digit seven-segment display between NUM_CLIENTS
// requesters: round-robin grant, fixed dwell, optional blanking gap.
// Define LED_SCHED_LIVE_EN to re-register the owner's pattern every SHOW
// cycle (one-cycle lag) instead of latching it once in LOAD.
module led_digits_scheduler
  import led_digits_pkg::*;
#(
  parameter int NUM_CLIENTS  = 4,
  parameter int DWELL_CYCLES = 12000000,
  parameter int BLANK_CYCLES = 120000
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_CLIENTS-1:0]            req_i,
  input  logic [SEG_BITS_C*NUM_CLIENTS-1:0] pattern_i,
  output logic [NUM_CLIENTS-1:0]            grant_o,
  output logic [NUM_CLIENTS-1:0]            done_o,
  output logic [SEG_BITS_C-1:0]             segments_o,
  output logic [2:0]                        owner_o,
  output logic                              active_o
);

  localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int DW = $clog2(DWELL_CYCLES + 1);
  localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0] BLANK_LOAD = (BLANK_CYCLES > 0) ? BW'(BLANK_CYCLES - 1) : '0;
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_CLIENTS - 1);

  sched_state_e                  state, state_nxt;
  logic [NUM_CLIENTS-1:0]        grant, grant_nxt;
  logic [NUM_CLIENTS-1:0]        done, done_nxt;
  logic [SEG_BITS_C-1:0]         seg, seg_nxt;
  logic [IW-1:0]                 owner, owner_nxt;
  logic [IW-1:0]                 rr_ptr, rr_ptr_nxt;
  logic [DW-1:0]                 dwell_cnt, dwell_nxt;
  logic [BW-1:0]                 blank_cnt, blank_nxt;

  logic [NUM_CLIENTS-1:0][SEG_BITS_C-1:0] pat_arr;
  logic [SEG_BITS_C-1:0]         owner_pat;
  logic [NUM_CLIENTS-1:0]        pick_oh;
  logic [IW-1:0]                 pick_idx;

  assign pat_arr   = pattern_i;
  assign owner_pat = pat_arr[owner];

  rr_arbiter #(.N(NUM_CLIENTS), .IW(IW)) u_arb (
    .req     (req_i),
    .pointer (rr_ptr),
    .onehot  (pick_oh),
    .index   (pick_idx)
  );

  // State and output registers; synchronous reset returns to blank IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      grant     <= '0;
      done      <= '0;
      seg       <= BLANK_PATTERN_C;
      owner     <= '0;
      rr_ptr    <= '0;
      dwell_cnt <= '0;
      blank_cnt <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      done      <= done_nxt;
      seg       <= seg_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_ptr_nxt;
      dwell_cnt <= dwell_nxt;
      blank_cnt <= blank_nxt;
    end
  end

  // Next-state and next-output logic; done is a pulse so it defaults low.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    done_nxt   = '0;
    seg_nxt    = seg;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    dwell_nxt  = dwell_cnt;
    blank_nxt  = blank_cnt;
    case (state)
      ST_IDLE: begin
        seg_nxt = BLANK_PATTERN_C;
        if (|req_i) begin
          state_nxt = ST_LOAD;
          grant_nxt = pick_oh;
          owner_nxt = pick_idx;
        end
      end
      ST_LOAD: begin
        seg_nxt   = owner_pat;
        dwell_nxt = DWELL_LOAD;
        state_nxt = ST_SHOW;
      end
      ST_SHOW: begin
`ifdef LED_SCHED_LIVE_EN
        seg_nxt = owner_pat;
`endif
        // Expiry wins over a simultaneous request drop, so done still pulses.
        if (dwell_cnt == '0 || !req_i[owner]) begin
          done_nxt[owner] = (dwell_cnt == '0);
          grant_nxt       = '0;
          seg_nxt         = BLANK_PATTERN_C;
          rr_ptr_nxt      = (owner == LAST_IDX) ? '0 : owner + IW'(1);
          if (BLANK_CYCLES == 0) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_BLANK;
            blank_nxt = BLANK_LOAD;
          end
        end else begin
          dwell_nxt = dwell_cnt - DW'(1);
        end
      end
      ST_BLANK: begin
        seg_nxt = BLANK_PATTERN_C;
        if (blank_cnt == '0) state_nxt = ST_IDLE;
        else                 blank_nxt = blank_cnt - BW'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign grant_o    = grant;
  assign done_o     = done;
  assign segments_o = seg;
  assign owner_o    = 3'(owner);
  assign active_o   = (state == ST_LOAD) || (state == ST_SHOW);

endmodule
